muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide instructions.
- Sits beside the single-cycle integer ALU in the execute stage. The pipeline stalls on it through a valid/ready request and response handshake.
- Computes one shift-add or shift-subtract step per clock on operand magnitudes, then applies sign correction.
- Div-by-zero and signed overflow take a fast path with fixed RISC-V results.

---
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: one shift-add / restoring-subtract step per clock
// on operand magnitudes, sign fix-up at the end, fixed results for div-by-zero and overflow.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned CNT_WIDTH = $clog2(WIDTH) + 1;
    localparam int unsigned PW        = 2 * WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WIDTH - 1);
    localparam logic [WIDTH-1:0]     MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [2:0]             op_q;
    logic                   neg_res_q;
    logic                   neg_rem_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       res_q;
    logic                   resp_valid_q;

    // Request decode: signedness, magnitudes and the fixed-result fast path
    logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic             div_zero, div_ovf, fast;
    logic [WIDTH-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        is_div   = op[2];
        a_sgn    = is_div ? !op[0] : (op[1:0] != 2'b11);
        b_sgn    = is_div ? !op[0] : !op[1];
        a_neg    = a_sgn & a[WIDTH-1];
        b_neg    = b_sgn & b[WIDTH-1];
        a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && !op[0] && (a == MIN_NEG) && (b == '1);
        fast     = div_zero || div_ovf;
        fast_res = a;
        if (div_zero) begin
            fast_res = op[1] ? a : '1;
        end else if (op[1]) begin
            fast_res = '0;
        end
    end

    // One iteration step: multiply adds into the high half then shifts right;
    // divide shifts the next dividend bit into the remainder and trial-subtracts.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_ge    = !div_diff[WIDTH];
        if (op_q[2]) begin
            hi_step = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction and result selection
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fix_res;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_res_q ? (~prod + PW'(1)) : prod;
        quo_fix  = neg_res_q ? (~lo_q + WIDTH'(1)) : lo_q;
        rem_fix  = neg_rem_q ? (~hi_q + WIDTH'(1)) : hi_q;
        if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[PW-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            neg_res_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            mcand_q      <= '0;
            res_q        <= '0;
            resp_valid_q <= 1'b0;
        end else if (flush) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        if (fast) begin
                            res_q        <= fast_res;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            lo_q    <= is_div ? a_mag : b_mag;
                            mcand_q <= is_div ? b_mag : a_mag;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= hi_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    res_q        <= fix_res;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready must fall with flush in the same cycle, and stay low while reset is held
    assign req_ready  = rst_n && (state_q == S_IDLE) && !flush;
    assign resp_valid = resp_valid_q;
    assign res        = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: one task per scenario, hand-computed expected values.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] res;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int NORM_LAT = 33;  // resp_valid visible after edge E0+WIDTH+1

    muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .res        (res)
    );

    always #5 clk = ~clk;

    // Called just after a negedge. Returns result, edges from accept until resp_valid seen,
    // and whether req_ready was ever high while the operation was outstanding.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat, output bit rdy_seen);
        req_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0; rdy_seen = 1'b0;
        while (resp_valid !== 1'b1 && lat < 100) begin
            if (req_ready === 1'b1) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        r = res;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0;
        #3;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL reset_res got=%h exp=0", res); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_mul;
        logic [2:0]  ops [4] = '{MUL, MULH, MULHU, MULHSU};
        logic [31:0] xa  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] xb  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2};
        logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] r; int lat; bit rdy;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xa[i], xb[i], r, lat, rdy);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL mul_res[%0d] got=%h exp=%h", i, r, exp[i]); end
            total++; if (lat != NORM_LAT) begin bad++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, lat, NORM_LAT); end
            total++; if (rdy !== 1'b0) begin bad++; $display("FAIL mul_busy_ready[%0d] got=%b exp=0", i, rdy); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [4] = '{DIV, REM, DIVU, REMU};
        logic [31:0] xa  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] xb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [31:0] r; int lat; bit rdy;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xa[i], xb[i], r, lat, rdy);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL div_res[%0d] got=%h exp=%h", i, r, exp[i]); end
            total++; if (lat != NORM_LAT) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, NORM_LAT); end
        end
    endtask

    task automatic test_fast_path;
        logic [2:0]  ops [4] = '{DIVU, REM, DIV, REM};
        logic [31:0] xa  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] xb  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] r; int lat; bit rdy;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xa[i], xb[i], r, lat, rdy);
            total++; if (r !== exp[i]) begin bad++; $display("FAIL fast_res[%0d] got=%h exp=%h", i, r, exp[i]); end
            total++; if (lat != 0) begin bad++; $display("FAIL fast_latency[%0d] got=%0d exp=0", i, lat); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; int lat; bit rdy; bit stable; int wait_n;
        req_valid = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_n = 0;
        while (resp_valid !== 1'b1 && wait_n < 100) begin @(negedge clk); wait_n++; end
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_timeout got=%b exp=1", resp_valid); end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            resp_ready = 1'b0; req_valid = 1'b1; op = MUL; a = 32'd3; b = 32'd5;
            @(negedge clk);
            if (resp_valid !== 1'b1 || res !== 32'd14 || req_ready !== 1'b0) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_hold_stable got=%b exp=1 (res=%h)", stable, res); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_hs got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after_hs got=%b exp=0", resp_valid); end
        issue(MUL, 32'd3, 32'd5, r, lat, rdy);
        total++; if (r !== 32'd15) begin bad++; $display("FAIL b2b_res got=%h exp=%h", r, 32'd15); end
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    task automatic test_flush;
        logic [31:0] r; int lat; bit rdy; bit leak;
        req_valid = 1'b1; op = MUL; a = 32'd123; b = 32'd456;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_calc_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_to_idle got=%b exp=1", req_ready); end
        leak = 1'b0;
        repeat (40) begin @(negedge clk); if (resp_valid !== 1'b0) leak = 1'b1; end
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL flush_resp_leak got=%b exp=0", leak); end
        issue(REMU, 32'd100, 32'd7, r, lat, rdy);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL flush_next_res got=%h exp=%h", r, 32'd2); end
        flush = 1'b1; req_valid = 1'b1; op = DIVU; a = 32'd5; b = 32'd0;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready got=%b exp=0", req_ready); end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_accept got=%b exp=0", resp_valid); end
    endtask

    task automatic test_async_reset;
        logic [31:0] r; int lat; bit rdy; bit leak;
        req_valid = 1'b1; op = MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL arst_resp_valid got=%b exp=0", resp_valid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL arst_req_ready got=%b exp=0", req_ready); end
        total++; if (res !== 32'h0) begin bad++; $display("FAIL arst_res got=%h exp=0", res); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL arst_release_ready got=%b exp=1", req_ready); end
        leak = 1'b0;
        repeat (40) begin @(negedge clk); if (resp_valid !== 1'b0) leak = 1'b1; end
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL arst_resp_leak got=%b exp=0", leak); end
        issue(DIV, 32'hFFFFFFF9, 32'd2, r, lat, rdy);
        total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL arst_next_res got=%h exp=%h", r, 32'hFFFFFFFD); end
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL arst_next_latency got=%0d exp=%0d", lat, NORM_LAT); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
